// File: rtl/qbus_mem_slave_if.sv
// Q-bus slave-side signal bundle: inverted AD bus, strobes and reply.
interface qbus_mem_slave_if;
   logic [15:0] ad_n_in;
   logic [15:0] ad_n_out;
   logic        ad_n_oe;
   logic        sync_n;
   logic        din_n;
   logic        dout_n;
   logic        wtbt_n;
   logic        rply_n;
   logic        sel;

   modport slave (
      input  ad_n_in, sync_n, din_n, dout_n, wtbt_n,
      output ad_n_out, ad_n_oe, rply_n, sel
   );

   modport master (
      output ad_n_in, sync_n, din_n, dout_n, wtbt_n,
      input  ad_n_out, ad_n_oe, rply_n, sel
   );
endinterface

// File: rtl/qbus_mem_slave.sv
// Q-bus memory responder: decodes SYNC/DIN/DOUT/WTBT cycles from the LSI-11
// core and serves them from an internal word RAM, answering with RPLY.
// Optional write protect input is enabled by defining QMEM_WP_EN.
module qbus_mem_slave #(
   parameter int unsigned ADDR_W   = 12,
   parameter logic [15:0] BASE     = 16'o000000,
   parameter int unsigned RPLY_DLY = 1
) (
   input logic clk,
   input logic rst_n,
`ifdef QMEM_WP_EN
   input logic wp,
`endif
   qbus_mem_slave_if.slave bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = (RPLY_DLY > 0) ? CNT_W'(RPLY_DLY - 1) : '0;
   localparam logic SKIP_DLY = (RPLY_DLY == 0);

   typedef enum logic [2:0] {
      IDLE, ADDR, SEL, DLY, RD_RPLY, WR_RPLY, WAIT_END
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        s1_q, s2_q;
   logic [15:0]       ad_q;
   logic [15:0]       addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              is_rd_q, is_rd_d;
   logic              rply_q, rply_d;
   logic              oe_q, oe_d;
   logic              sel_q, sel_d;
   logic [15:0]       ad_out_q;
   logic [15:0]       wdata_q;
   logic              wbyte_q;
   logic              rd_en, wr_en, cap_en;
   logic              sync_s, din_s, dout_s, wtbt_s;
   logic              hit;
   logic [ADDR_W-1:0] idx;
   logic [15:0]       wd_c;
   logic              bw_c;
   logic              wp_c;
   logic              lo_we, hi_we;
   logic [7:0]        hi_data;
   logic [15:0]       mem [DEPTH];

   assign sync_s = s2_q[3];
   assign din_s  = s2_q[2];
   assign dout_s = s2_q[1];
   assign wtbt_s = s2_q[0];

   assign hit = (addr_q[15:ADDR_W+1] == BASE[15:ADDR_W+1]);
   assign idx = addr_q[ADDR_W:1];

   // Strobe synchronizers and AD bus capture aligned with the first stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 4'hF;
         s2_q <= 4'hF;
         ad_q <= 16'hFFFF;
      end else begin
         s1_q <= {bus.sync_n, bus.din_n, bus.dout_n, bus.wtbt_n};
         s2_q <= s1_q;
         ad_q <= bus.ad_n_in;
      end
   end

   // Bus cycle sequencing and registered output values
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      is_rd_d = is_rd_q;
      sel_d   = sel_q;
      rply_d  = 1'b1;
      oe_d    = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      cap_en  = 1'b0;
      case (state_q)
         IDLE: begin
            sel_d = 1'b0;
            if (!sync_s) begin
               state_d = ADDR;
               addr_d  = ~ad_q;
            end
         end
         ADDR: begin
            if (hit) begin
               state_d = SEL;
               sel_d   = 1'b1;
            end else begin
               state_d = WAIT_END;
            end
         end
         SEL: begin
            // DIN wins when both strobes are seen together
            if (!din_s || !dout_s) begin
               is_rd_d = !din_s;
               rd_en   = !din_s;
               cap_en  = din_s;
               if (SKIP_DLY) begin
                  state_d = !din_s ? RD_RPLY : WR_RPLY;
                  wr_en   = din_s;
               end else begin
                  state_d = DLY;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         DLY: begin
            if (cnt_q == '0) begin
               state_d = is_rd_q ? RD_RPLY : WR_RPLY;
               wr_en   = !is_rd_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RD_RPLY: begin
            if (din_s) begin
               state_d = SEL;
            end else begin
               rply_d = 1'b0;
               oe_d   = 1'b1;
            end
         end
         WR_RPLY: begin
            if (dout_s) begin
               state_d = SEL;
            end else begin
               rply_d = 1'b0;
            end
         end
         WAIT_END: begin
            state_d = WAIT_END;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // End of SYNC aborts everything and releases the bus on this edge
      if (sync_s && (state_q != IDLE)) begin
         state_d = IDLE;
         sel_d   = 1'b0;
         rply_d  = 1'b1;
         oe_d    = 1'b0;
         rd_en   = 1'b0;
         wr_en   = 1'b0;
         cap_en  = 1'b0;
      end
   end

   // State, address latch, read data and write capture registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         is_rd_q  <= 1'b0;
         sel_q    <= 1'b0;
         rply_q   <= 1'b1;
         oe_q     <= 1'b0;
         ad_out_q <= 16'hFFFF;
         wdata_q  <= '0;
         wbyte_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         is_rd_q <= is_rd_d;
         sel_q   <= sel_d;
         rply_q  <= rply_d;
         oe_q    <= oe_d;
         if (rd_en) begin
            ad_out_q <= ~mem[idx];
         end else if (state_d == IDLE) begin
            ad_out_q <= 16'hFFFF;
         end
         if (cap_en) begin
            wdata_q <= ~ad_q;
            wbyte_q <= ~wtbt_s;
         end
      end
   end

   // Write operands come live from the bus when DLY is skipped
   assign wd_c = (state_q == SEL) ? ~ad_q : wdata_q;
   assign bw_c = (state_q == SEL) ? ~wtbt_s : wbyte_q;

`ifdef QMEM_WP_EN
   logic wp_q;

   // Write protect sampled at DOUT recognition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q <= 1'b0;
      end else if (cap_en) begin
         wp_q <= wp;
      end
   end

   assign wp_c = (state_q == SEL) ? wp : wp_q;
`else
   assign wp_c = 1'b0;
`endif

   // Byte writes take the low data byte into whichever lane addr[0] picks
   assign lo_we   = wr_en & ~wp_c & (~bw_c | ~addr_q[0]);
   assign hi_we   = wr_en & ~wp_c & (~bw_c |  addr_q[0]);
   assign hi_data = bw_c ? wd_c[7:0] : wd_c[15:8];

   // RAM lane writes
   always_ff @(posedge clk) begin
      if (lo_we) begin
         mem[idx][7:0] <= wd_c[7:0];
      end
      if (hi_we) begin
         mem[idx][15:8] <= hi_data;
      end
   end

   assign bus.ad_n_out = ad_out_q;
   assign bus.ad_n_oe  = oe_q;
   assign bus.rply_n   = rply_q;
   assign bus.sel      = sel_q;

endmodule

// File: tb/tb_qbus_mem_slave.sv
// Self-checking bench for qbus_mem_slave: directed cycles plus random
// DATI/DATO/DATOB/DATIO traffic against a word-array memory model.
module tb_qbus_mem_slave;

   localparam int RPLY_DLY = 1;
   localparam int LAT      = 3 + RPLY_DLY;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wp_bit = 1'b0;

   always #5 clk = ~clk;

   qbus_mem_slave_if bus();

   qbus_mem_slave #(
      .ADDR_W  (12),
      .BASE    (16'o000000),
      .RPLY_DLY(RPLY_DLY)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
`ifdef QMEM_WP_EN
      .wp   (wp_bit),
`endif
      .bus  (bus)
   );

   int tests = 0;
   int fails = 0;

   logic        chk_en = 1'b0;
   logic        exp_exact = 1'b0;
   logic        exp_rply = 1'b1;
   logic        exp_oe = 1'b0;
   logic        exp_sel_en = 1'b0;
   logic        exp_sel = 1'b0;
   logic [15:0] exp_data = 16'h0000;
   int          rply_falls = 0;
   logic [15:0] model [4096];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic in_window(input logic [15:0] a);
      return a[15:13] == 3'b000;
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a);
      return model[a[12:1]];
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [15:0] d, input logic bw);
      logic [15:0] w;
      if (!in_window(a) || wp_bit) return;
      w = model[a[12:1]];
      if (!bw)       w = d;
      else if (a[0]) w[15:8] = d[7:0];
      else           w[7:0] = d[7:0];
      model[a[12:1]] = w;
   endtask

   // Per-cycle compare of DUT outputs against the current expectations
   initial begin
      logic prev_rply;
      prev_rply = 1'b1;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (exp_exact) begin
               check("rply_n", 16'(bus.rply_n), 16'(exp_rply));
               check("ad_n_oe", 16'(bus.ad_n_oe), 16'(exp_oe));
            end
            if (bus.ad_n_oe) check("ad_n_out", bus.ad_n_out, ~exp_data);
            if (exp_sel_en) check("sel", 16'(bus.sel), 16'(exp_sel));
         end
         if (prev_rply && !bus.rply_n) rply_falls++;
         prev_rply = bus.rply_n;
      end
   end

   task automatic start_sync(input logic [15:0] a, input logic wr);
      @(posedge clk); #1;
      bus.ad_n_in = ~a;
      bus.wtbt_n  = ~wr;
      bus.sync_n  = 1'b0;
      exp_sel_en  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.ad_n_in = 16'hFFFF;
      bus.wtbt_n  = 1'b1;
      exp_sel     = in_window(a);
      exp_sel_en  = 1'b1;
   endtask

   task automatic end_sync;
      @(posedge clk); #1;
      bus.sync_n = 1'b1;
      exp_sel_en = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      exp_sel    = 1'b0;
      exp_sel_en = 1'b1;
   endtask

   // One DIN or DOUT strobe with exact RPLY timing expectations
   task automatic strobe(input logic rd, input logic hit, input logic [15:0] d,
                         input logic bw, output logic [15:0] got);
      logic done;
      @(posedge clk); #1;
      if (rd) begin
         exp_data   = d;
         bus.din_n  = 1'b0;
      end else begin
         bus.ad_n_in = ~d;
         bus.wtbt_n  = ~bw;
         bus.dout_n  = 1'b0;
      end
      exp_exact = 1'b1;
      exp_rply  = 1'b1;
      exp_oe    = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(posedge clk); #1;
         exp_rply = !(hit && k >= LAT);
         exp_oe   = rd && hit && k >= LAT;
         if (rd && hit && k == LAT - 1) begin
            @(negedge clk);
            check("rd_data_setup", bus.ad_n_out, ~d);
         end
      end
      @(negedge clk);
      got = ~bus.ad_n_out;
      @(posedge clk); #1;
      bus.din_n   = 1'b1;
      bus.dout_n  = 1'b1;
      bus.ad_n_in = 16'hFFFF;
      bus.wtbt_n  = 1'b1;
      exp_exact   = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge clk);
         done = bus.rply_n && !bus.ad_n_oe;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL strobe_release: rply_n=%b ad_n_oe=%b, required 1/0 within 8 clks",
                  bus.rply_n, bus.ad_n_oe);
      end
      @(posedge clk); #1;
      exp_rply  = 1'b1;
      exp_oe    = 1'b0;
      exp_exact = 1'b1;
   endtask

   task automatic dati(input logic [15:0] a, output logic [15:0] got);
      start_sync(a, 1'b0);
      strobe(1'b1, in_window(a), in_window(a) ? model_read(a) : 16'h0000, 1'b0, got);
      end_sync();
   endtask

   task automatic dato(input logic [15:0] a, input logic [15:0] d, input logic bw);
      logic [15:0] dummy;
      start_sync(a, 1'b1);
      strobe(1'b0, in_window(a), d, bw, dummy);
      model_write(a, d, bw);
      end_sync();
   endtask

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] got;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] pool [6];
      int          falls0;
      logic        done;

      bus.ad_n_in = 16'hFFFF;
      bus.sync_n  = 1'b1;
      bus.din_n   = 1'b1;
      bus.dout_n  = 1'b1;
      bus.wtbt_n  = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("reset_rply_n", 16'(bus.rply_n), 16'h0001);
      check("reset_ad_n_oe", 16'(bus.ad_n_oe), 16'h0000);
      check("reset_ad_n_out", bus.ad_n_out, 16'hFFFF);
      check("reset_sel", 16'(bus.sel), 16'h0000);
      @(posedge clk); #1;
      rst_n      = 1'b1;
      exp_exact  = 1'b1;
      exp_sel_en = 1'b1;
      chk_en     = 1'b1;
      repeat (3) @(posedge clk);

      // Word write then read
      dato(16'o001000, 16'o123456, 1'b0);
      dati(16'o001000, got);
      check("word_rd", got, 16'o123456);

      // Byte lanes
      dato(16'o002000, 16'o000000, 1'b0);
      dato(16'o002001, 16'o000377, 1'b1);
      dati(16'o002000, got);
      check("byte_hi_rd", got, 16'o177400);
      dato(16'o002000, 16'o000125, 1'b1);
      dati(16'o002000, got);
      check("byte_lo_rd", got, 16'o177525);

      // Out of window: no reply, no drive, sel low (exact compares in strobe)
      dati(16'o020000, got);

      // DATIO: read then write inside one SYNC
      dato(16'o003000, 16'o000777, 1'b0);
      falls0 = rply_falls;
      start_sync(16'o003000, 1'b0);
      strobe(1'b1, 1'b1, model_read(16'o003000), 1'b0, got);
      check("datio_rd", got, 16'o000777);
      strobe(1'b0, 1'b1, 16'o000001, 1'b0, got);
      model_write(16'o003000, 16'o000001, 1'b0);
      end_sync();
      check("datio_pulses", 16'(rply_falls - falls0), 16'd2);
      dati(16'o003000, got);
      check("datio_after", got, 16'o000001);

      // Reset during RD_RPLY releases the bus asynchronously
      dato(16'o004000, 16'o055555, 1'b0);
      start_sync(16'o004000, 1'b0);
      @(posedge clk); #1;
      exp_data  = model_read(16'o004000);
      exp_exact = 1'b0;
      bus.din_n = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         @(negedge clk);
         done = !bus.rply_n;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL rst_setup: rply_n=%b, required 0 within 10 clks", bus.rply_n);
      end
      @(posedge clk); #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("rst_async_rply_n", 16'(bus.rply_n), 16'h0001);
      check("rst_async_ad_n_oe", 16'(bus.ad_n_oe), 16'h0000);
      @(posedge clk); #1;
      bus.sync_n = 1'b1;
      bus.din_n  = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_rply   = 1'b1;
      exp_oe     = 1'b0;
      exp_exact  = 1'b1;
      exp_sel    = 1'b0;
      exp_sel_en = 1'b1;
      chk_en     = 1'b1;
      dato(16'o004002, 16'o012345, 1'b0);
      dati(16'o004002, got);
      check("post_reset_rd", got, 16'o012345);

`ifdef QMEM_WP_EN
      // Write protect suppresses the write but still replies
      dato(16'o005000, 16'o000007, 1'b0);
      wp_bit = 1'b1;
      dato(16'o005000, 16'o111111, 1'b0);
      wp_bit = 1'b0;
      dati(16'o005000, got);
      check("wp_rd", got, 16'o000007);
`endif

      // Random traffic over a small pool of words
      for (int i = 0; i < 6; i++) begin
         pool[i] = 16'o006000 + 16'($urandom_range(0, 255) << 1);
         dato(pool[i], 16'($urandom), 1'b0);
      end
      for (int n = 0; n < 40; n++) begin
         a = pool[$urandom_range(0, 5)];
         d = 16'($urandom);
         case ($urandom_range(0, 5))
            0: dato(a, d, 1'b0);
            1: dato(a | 16'($urandom_range(0, 1)), d, 1'b1);
            2, 3: begin
               d = model_read(a);
               dati(a, got);
               check("rand_rd", got, d);
            end
            4: dato(a | 16'($urandom_range(1, 7) << 13), d, 1'b0);
            default: begin
               start_sync(a, 1'b0);
               strobe(1'b1, 1'b1, model_read(a), 1'b0, got);
               check("rand_datio_rd", got, model_read(a));
               strobe(1'b0, 1'b1, d, 1'b0, got);
               model_write(a, d, 1'b0);
               end_sync();
            end
         endcase
      end
      for (int i = 0; i < 6; i++) begin
         d = model_read(pool[i]);
         dati(pool[i], got);
         check("final_rd", got, d);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
